serial_fifo_ctrl: RTL and testbench
===================================

# serial_fifo_ctrl

Buffered successor to the single-byte serial controller, placed between `devctrl` (COM window) and the `async_receiver`/`async_transmitter` pair in `thinpad_top`. It holds received bytes in a parametrised RX FIFO and queued output bytes in a parametrised TX FIFO. A TX state machine drains the TX FIFO into the transmitter. The block exposes data, status and control registers to the CPU and drives a maskable level interrupt on `int_o`, which feeds `int_i[2]`.

## Interface
- `RX_DEPTH_LOG2`, 4: RX FIFO holds 2^N bytes. Legal range 1..7.
- `TX_DEPTH_LOG2`, 4: TX FIFO holds 2^N bytes. Legal range 1..7.
- `RX_INT_LEVEL`, 1: RX interrupt fires when RX count >= this value. Legal range 1..2^RX_DEPTH_LOG2.
- `clk`  in  1  system clock (clk25)
- `rst`  in  1  reset, asynchronous, active-high
- `enable_i`  in  1  register access strobe; one access per asserted cycle
- `readEnable_i`  in  1  1 = read, 0 = write
- `addr_i`  in  2  register select (physical addr[3:2])
- `dataSave_i`  in  32  write data
- `dataLoad_o`  out  32  read data, combinational
- `int_o`  out  1  interrupt level, registered
- `rxdReady_i`  in  1  one-cycle pulse, `rxdData_i` valid
- `rxdData_i`  in  8  received byte
- `txdBusy_i`  in  1  transmitter busy
- `txdStart_o`  out  1  one-cycle start pulse to transmitter
- `txdData_o`  out  8  byte to transmit, registered

## Operation
- **addr 0, DATA**
  - Read returns {24'h0, RX head} and pops at the clock edge.
  - If RX is empty, a read returns 0 and does not pop.
  - Write pushes `dataSave_i[7:0]` into TX.
  - If TX is full, the write is dropped and the sticky `txOverflow` bit is set.
- **addr 1, STATUS**
  - Read bits: [0] rxNotEmpty, [1] txNotFull, [2] rxOverrun (sticky), [3] txOverflow (sticky), [4] txIdle (TX empty and FSM in IDLE), [15:8] rxCount, [23:16] txCount. All other bits read 0.
  - Counts are zero-extended to 8 bits.
  - A write with bit2 = 1 clears rxOverrun; a write with bit3 = 1 clears txOverflow. Other bits are ignored.
- **addr 2, CONTROL**
  - Read/write: [0] rxIntEn, [1] txIntEn. All other bits read 0.
- **addr 3**: reads 0; writes are ignored.
- **RX push**: on `rxdReady_i`, push `rxdData_i`. If RX is full, the byte is dropped and rxOverrun is set.
- **Simultaneous RX push and pop**
  - Non-empty, non-full RX: both operations occur and the count is unchanged.
  - Empty RX: the pop is ignored (read returns 0) and the push proceeds.
  - Full RX: the pop frees a slot, the push succeeds, and rxOverrun is not set.
- **Simultaneous TX push (CPU) and pop (FSM)**: same rules as RX.
- **FIFOs**: circular buffers. Pointers are DEPTH_LOG2 bits and wrap modulo depth. Counts are DEPTH_LOG2+1 bits.
- **TX FSM**
  - IDLE -> LOAD when TX is non-empty and `txdBusy_i` = 0. In LOAD, `txdData_o` <= head and pop.
  - LOAD -> START. In START, `txdStart_o` = 1 for one cycle.
  - START -> HOLD: one cycle, allowing busy to rise.
  - HOLD -> WAITDONE.
  - WAITDONE -> IDLE when `txdBusy_i` = 0.
- **Interrupt**: `int_o` <= (rxIntEn & rxCount >= RX_INT_LEVEL) | (txIntEn & txIdle). Overrun/overflow bits do not raise the interrupt.

## Timing
- **Reset values**: while `rst` = 1 (asynchronous):
  - Pointers and counts are 0; FSM is in IDLE.
  - `txdStart_o` = 0, `txdData_o` = 0, `int_o` = 0.
  - CONTROL = 0; sticky bits = 0.
  - FIFO contents are don't-care.
- **Reset mid-operation**: a byte in flight at the transmitter is abandoned by this block; all queued bytes are discarded.
- **Read latency**: 0 cycles. `dataLoad_o` reflects state before the edge. A pop or write takes effect at the edge that ends the access cycle.
- **STATUS after accesses**: a read in cycle n+1 sees the effects of all accesses and pushes from cycle n.
- **TX pipeline**: for a DATA write at edge n into empty TX with an idle FSM:
  - FSM is in LOAD during cycle n+1.
  - `txdData_o` is valid and `txdStart_o` = 1 during cycle n+2.
  - txCount drops at edge n+2.
- **Back-to-back transmission**: consecutive bytes start no sooner than one cycle after `txdBusy_i` falls.
- **int_o lag**: `int_o` lags its causing condition by one cycle.

## Test plan
- **Reset**: assert `rst` mid-transmission -> all outputs 0 immediately; STATUS reads 0x00000012 after release (txNotFull = 1, txIdle = 1).
- **RX fill and drain**: RX_DEPTH_LOG2 = 2; pulse `rxdReady_i` with 0x11..0x15 -> rxCount = 4, rxOverrun = 1; DATA reads return 0x11, 0x12, 0x13, 0x14, then 0; write STATUS bit2 -> rxOverrun = 0.
- **TX ordering**: write 0x41, 0x42, 0x43 in consecutive cycles; model busy for 10 cycles after each start -> exactly three `txdStart_o` pulses carrying 0x41, 0x42, 0x43 in order, none while busy; txIdle returns to 1.
- **Simultaneous full RX**: RX full plus DATA read and `rxdReady_i` in the same cycle -> read returns the old head, rxCount stays full, rxOverrun stays 0, and the new byte is read last.
- **Interrupt**: RX_INT_LEVEL = 2, rxIntEn = 1.
  - One RX byte -> `int_o` = 0.
  - Second byte -> `int_o` = 1 one cycle later.
  - One read -> `int_o` = 0.
  - txIntEn = 1 with TX idle -> `int_o` = 1.
- **TX full**: TX_DEPTH_LOG2 = 1, `txdBusy_i` held 1; write four bytes -> txCount = 2, txOverflow = 1; first two bytes are sent after busy is released.

Source files
------------

// File: rtl/serial_fifo_ctrl.sv
// Buffered serial controller: RX/TX byte FIFOs between the CPU register window
// and the async receiver/transmitter pair, with a TX drain FSM and level interrupt.
module serial_fifo_ctrl #(
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_INT_LEVEL  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o
);

  localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int unsigned RX_CW    = RX_DEPTH_LOG2 + 1;
  localparam int unsigned TX_CW    = TX_DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_START, ST_HOLD, ST_WAITDONE
  } tx_state_e;

  logic [7:0]               rx_mem_q [RX_DEPTH];
  logic [7:0]               tx_mem_q [TX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [RX_CW-1:0]         rx_count_q, rx_count_d;
  logic [TX_CW-1:0]         tx_count_q, tx_count_d;
  logic                     rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
  logic                     rx_int_en_q, rx_int_en_d, tx_int_en_q, tx_int_en_d;
  logic                     int_q, int_d;
  tx_state_e                state_q;
  logic [7:0]               txd_data_q;
  logic                     txd_start_q;

  logic cpu_wr, cpu_rd, rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop, tx_idle;
  logic unused_save_bits;

  assign unused_save_bits = ^dataSave_i[31:8];

  // FIFO push/pop arbitration, sticky flags and control register
  always_comb begin
    cpu_wr   = enable_i & ~readEnable_i;
    cpu_rd   = enable_i & readEnable_i;
    rx_empty = (rx_count_q == '0);
    rx_full  = (rx_count_q == RX_CW'(RX_DEPTH));
    tx_empty = (tx_count_q == '0);
    tx_full  = (tx_count_q == TX_CW'(TX_DEPTH));

    rx_pop  = cpu_rd & (addr_i == 2'd0) & ~rx_empty;
    rx_push = rxdReady_i & (~rx_full | rx_pop);
    tx_pop  = (state_q == ST_LOAD) & ~tx_empty;
    tx_push = cpu_wr & (addr_i == 2'd0) & (~tx_full | tx_pop);

    rx_count_d  = rx_count_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
    tx_count_d  = tx_count_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + RX_DEPTH_LOG2'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + RX_DEPTH_LOG2'(1) : rx_rd_ptr_q;
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + TX_DEPTH_LOG2'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + TX_DEPTH_LOG2'(1) : tx_rd_ptr_q;

    // a new drop in the same cycle as a clear keeps the flag set
    rx_ovr_d = (rxdReady_i & rx_full & ~rx_pop) |
               (rx_ovr_q & ~(cpu_wr & (addr_i == 2'd1) & dataSave_i[2]));
    tx_ovf_d = (cpu_wr & (addr_i == 2'd0) & tx_full & ~tx_pop) |
               (tx_ovf_q & ~(cpu_wr & (addr_i == 2'd1) & dataSave_i[3]));

    rx_int_en_d = rx_int_en_q;
    tx_int_en_d = tx_int_en_q;
    if (cpu_wr && addr_i == 2'd2) begin
      rx_int_en_d = dataSave_i[0];
      tx_int_en_d = dataSave_i[1];
    end

    tx_idle = tx_empty & (state_q == ST_IDLE);
    int_d   = (rx_int_en_q & (rx_count_q >= RX_CW'(RX_INT_LEVEL))) |
              (tx_int_en_q & tx_idle);
  end

  // register read mux, zero latency
  always_comb begin
    dataLoad_o = '0;
    case (addr_i)
      2'd0: dataLoad_o = rx_empty ? 32'h0 : {24'h0, rx_mem_q[rx_rd_ptr_q]};
      2'd1: dataLoad_o = {8'h0, 8'(tx_count_q), 8'(rx_count_q), 3'b000,
                          tx_idle, tx_ovf_q, rx_ovr_q, ~tx_full, ~rx_empty};
      2'd2: dataLoad_o = {30'h0, tx_int_en_q, rx_int_en_q};
      default: dataLoad_o = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_count_q  <= '0;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      rx_int_en_q <= 1'b0;
      tx_int_en_q <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_count_q  <= tx_count_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_int_en_q <= rx_int_en_d;
      tx_int_en_q <= tx_int_en_d;
      int_q       <= int_d;
    end
  end

  // FIFO storage carries no reset
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rxdData_i;
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= dataSave_i[7:0];
  end

  // TX drain FSM: load head, pulse start, give busy a cycle to rise, wait done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      txd_data_q  <= '0;
      txd_start_q <= 1'b0;
    end else begin
      txd_start_q <= 1'b0;
      case (state_q)
        ST_IDLE:     if (!tx_empty && !txdBusy_i) state_q <= ST_LOAD;
        ST_LOAD: begin
          txd_data_q  <= tx_mem_q[tx_rd_ptr_q];
          txd_start_q <= 1'b1;
          state_q     <= ST_START;
        end
        ST_START:    state_q <= ST_HOLD;
        ST_HOLD:     state_q <= ST_WAITDONE;
        ST_WAITDONE: if (!txdBusy_i) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  assign int_o      = int_q;
  assign txdStart_o = txd_start_q;
  assign txdData_o  = txd_data_q;

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Randomized and directed bench for serial_fifo_ctrl against a queue-based model.
module tb_serial_fifo_ctrl;
  localparam int RXD = 4;
  localparam int TXD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i, readEnable_i, rxdReady_i, txdBusy_i;
  logic [1:0]  addr_i;
  logic [31:0] dataSave_i, dataLoad_o;
  logic [7:0]  rxdData_i, txdData_o;
  logic        int_o, txdStart_o;

  serial_fifo_ctrl #(.RX_DEPTH_LOG2(2), .TX_DEPTH_LOG2(1), .RX_INT_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .readEnable_i(readEnable_i),
    .addr_i(addr_i), .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o),
    .int_o(int_o), .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
    .txdBusy_i(txdBusy_i), .txdStart_o(txdStart_o), .txdData_o(txdData_o));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: byte queues, flags, plus a simple transmitter that stays busy after start
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         m_rxovr, m_txovr, m_rxen, m_txen, settled, pend_w, force_busy;
  logic [7:0] pend_b;
  int         busy_cnt, busy_len, cyc, starts;
  int         start_cyc[$];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    rx_q.delete(); tx_q.delete();
    m_rxovr = 0; m_txovr = 0; m_rxen = 0; m_txen = 0;
    settled = 1; pend_w = 0; busy_cnt = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    case (a)
      2'd0: return (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'h0;
      2'd1: return {8'h0, 8'(tx_q.size()), 8'(rx_q.size()), 3'b000, settled,
                    m_txovr, m_rxovr, tx_q.size() < TXD, rx_q.size() > 0};
      2'd2: return {30'h0, m_txen, m_rxen};
      default: return 32'h0;
    endcase
  endfunction

  // one clock cycle: drive after negedge, check read, update model at posedge, observe outputs
  task automatic step(input bit en, input bit rd, input logic [1:0] a,
                      input logic [31:0] d, input bit rv, input logic [7:0] rb);
    logic [31:0] msk;
    bit exp_int, int_chk;
    cyc++;
    enable_i = en; readEnable_i = rd; addr_i = a; dataSave_i = d;
    rxdReady_i = rv; rxdData_i = rb;
    txdBusy_i = force_busy || (busy_cnt > 0);
    #1;
    if (en && rd) begin
      msk = (a == 2'd1 && !settled) ? 32'hFFFF_FFEF : 32'hFFFF_FFFF;
      last_rd = dataLoad_o;
      check("read", dataLoad_o & msk, exp_read(a) & msk);
    end
    @(posedge clk);
    exp_int = (m_rxen && rx_q.size() >= 2) || (m_txen && settled && tx_q.size() == 0);
    int_chk = !(m_txen && !settled);
    if (en && !rd && a == 2'd1) begin
      if (d[2]) m_rxovr = 0;
      if (d[3]) m_txovr = 0;
    end
    if (en && rd && a == 2'd0 && rx_q.size() > 0) void'(rx_q.pop_front());
    if (rv) begin
      if (rx_q.size() < RXD) rx_q.push_back(rb);
      else m_rxovr = 1;
    end
    if (en && !rd && a == 2'd0) begin pend_w = 1; pend_b = d[7:0]; settled = 0; end
    if (en && !rd && a == 2'd2) begin m_rxen = d[0]; m_txen = d[1]; end
    if (busy_cnt > 0) busy_cnt--;
    @(negedge clk);
    if (int_chk) check("int", {31'h0, int_o}, {31'h0, exp_int});
    if (txdStart_o) begin
      starts++;
      start_cyc.push_back(cyc);
      check("start_while_busy", {31'h0, txdBusy_i}, 32'h0);
      check("tx_data", {24'h0, txdData_o}, (tx_q.size() > 0) ? {24'h0, tx_q[0]} : 32'h100);
      if (tx_q.size() > 0) void'(tx_q.pop_front());
      busy_cnt = (busy_len > 0) ? busy_len : int'($urandom_range(2, 10));
    end
    if (pend_w) begin
      if (tx_q.size() < TXD) tx_q.push_back(pend_b);
      else m_txovr = 1;
      pend_w = 0;
    end
  endtask

  task automatic idle();                                   step(0, 0, 2'd0, 32'h0, 0, 8'h0); endtask
  task automatic rdr(input logic [1:0] a);                 step(1, 1, a, 32'h0, 0, 8'h0);    endtask
  task automatic wrr(input logic [1:0] a, input logic [31:0] d); step(1, 0, a, d, 0, 8'h0);  endtask
  task automatic rxin(input logic [7:0] b);                step(0, 0, 2'd0, 32'h0, 1, b);    endtask

  task automatic settle();
    int n = 0;
    while ((tx_q.size() > 0 || busy_cnt > 0 || force_busy) && n < 300) begin idle(); n++; end
    check("settle_tx_drained", 32'(tx_q.size()), 32'h0);
    repeat (4) idle();
    settled = 1;
  endtask

  initial begin
    logic [7:0] exp_drain[5];
    int n, s0, w_cyc;
    rst = 1; enable_i = 0; readEnable_i = 0; addr_i = 0; dataSave_i = 0;
    rxdReady_i = 0; rxdData_i = 0; txdBusy_i = 0;
    force_busy = 0; busy_len = 10; cyc = 0; starts = 0; last_rd = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_start", {31'h0, txdStart_o}, 32'h0);
    check("rst_data", {24'h0, txdData_o}, 32'h0);
    check("rst_int", {31'h0, int_o}, 32'h0);
    rst = 0;
    rdr(2'd1);
    check("status_after_rst", last_rd, 32'h0000_0012);

    // reset mid-transmission
    wrr(2'd0, 32'h5A);
    n = 0;
    s0 = starts;
    while (starts == s0 && n < 10) begin idle(); n++; end
    check("mid_start_seen", 32'(starts - s0), 32'h1);
    rst = 1;
    #1;
    check("mid_rst_start", {31'h0, txdStart_o}, 32'h0);
    check("mid_rst_data", {24'h0, txdData_o}, 32'h0);
    check("mid_rst_int", {31'h0, int_o}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    m_reset();
    rdr(2'd1);
    check("status_after_mid_rst", last_rd, 32'h0000_0012);

    // RX fill and drain with overrun
    for (int i = 0; i < 5; i++) rxin(8'(8'h11 + i));
    rdr(2'd1);
    check("fill_status", last_rd, 32'h0000_0417);
    exp_drain = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    for (int i = 0; i < 5; i++) begin
      rdr(2'd0);
      check("drain", last_rd, {24'h0, exp_drain[i]});
    end
    wrr(2'd1, 32'h4);
    rdr(2'd1);
    check("ovr_cleared", last_rd, 32'h0000_0012);

    // simultaneous pop and push on full RX
    for (int i = 0; i < 4; i++) rxin(8'(8'hA0 + i));
    step(1, 1, 2'd0, 32'h0, 1, 8'hA4);
    check("full_pop_old_head", last_rd, 32'h0000_00A0);
    rdr(2'd1);
    check("full_pushpop_status", last_rd, 32'h0000_0413);
    for (int i = 1; i < 5; i++) begin
      rdr(2'd0);
      check("full_drain", last_rd, 32'(8'hA0 + i));
    end

    // TX ordering and pipeline latency
    s0 = starts;
    start_cyc.delete();
    wrr(2'd0, 32'h41);
    w_cyc = cyc;
    wrr(2'd0, 32'h42);
    wrr(2'd0, 32'h43);
    settle();
    check("tx_start_count", 32'(starts - s0), 32'd3);
    check("tx_latency", (start_cyc.size() > 0) ? 32'(start_cyc[0] - w_cyc) : 32'hFFFF, 32'd2);
    rdr(2'd1);
    check("tx_idle_again", last_rd, 32'h0000_0012);

    // interrupt threshold and tx-idle interrupt
    wrr(2'd2, 32'h1);
    rxin(8'h61);
    idle();
    check("int_one_byte", {31'h0, int_o}, 32'h0);
    rxin(8'h62);
    idle();
    check("int_two_bytes", {31'h0, int_o}, 32'h1);
    rdr(2'd0);
    idle();
    check("int_after_read", {31'h0, int_o}, 32'h0);
    wrr(2'd2, 32'h3);
    idle();
    check("int_tx_idle", {31'h0, int_o}, 32'h1);
    rdr(2'd2);
    check("ctrl_read", last_rd, 32'h3);
    rdr(2'd0);
    wrr(2'd2, 32'h0);

    // TX full with transmitter held busy
    force_busy = 1;
    s0 = starts;
    for (int i = 0; i < 4; i++) wrr(2'd0, 32'(8'h51 + i));
    rdr(2'd1);
    check("txfull_status", last_rd & 32'hFFFF_FFEF, 32'h0002_0008);
    force_busy = 0;
    settle();
    check("txfull_sent", 32'(starts - s0), 32'd2);
    wrr(2'd1, 32'h8);
    rdr(2'd3);
    check("addr3_read", last_rd, 32'h0);

    // randomized traffic; tx interrupt enable kept off so int_o is fully predictable
    busy_len = 0;
    for (int i = 0; i < 800; i++) begin
      bit en, rd, rv;
      logic [1:0] a;
      logic [31:0] d;
      en = ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 1) == 1);
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (a == 2'd2) d[1] = 1'b0;
      rv = ($urandom_range(0, 2) == 0);
      if (en && !rd && a == 2'd1) rv = 0;
      step(en, rd, a, d, rv, 8'($urandom));
    end
    settle();
    rdr(2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
